// File: rtl/num_den_divider.sv
// num_den_divider: 4-bit restoring divider with switch-loaded operands and LED display select.
module num_den_divider (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw,
  input  logic       btn_num,
  input  logic       btn_den,
  input  logic       btn_go,
  input  logic       btn_sel,
  output logic [3:0] conta_num,
  output logic [3:0] conta_den,
  output logic [3:0] cociente,
  output logic [3:0] resto,
  output logic [1:0] Sel,
  output logic       busy,
  output logic       done,
  output logic       div_zero
);
  typedef enum logic [1:0] {IDLE, DIV, FIN} state_t;
  state_t state, state_n;
  logic [3:0] divisor, q;
  logic [4:0] r, sh, r_n;
  logic [1:0] cnt;
  logic go_ok, den0, ge;
  always_comb begin
    go_ok = state == IDLE && btn_go && !btn_num && !btn_den;
    den0 = conta_den == 4'd0;
    sh = {r[3:0], q[3]};
    ge = sh >= {1'b0, divisor};
    r_n = ge ? sh - {1'b0, divisor} : sh;
    state_n = state == IDLE ? (go_ok ? (den0 ? FIN : DIV) : IDLE)
            : state == DIV ? (cnt == 2'd0 ? FIN : DIV) : IDLE;
  end
  assign busy = state == DIV;
  assign done = state == FIN;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  // results are written on entry to FIN so they are valid while done is high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conta_num <= '0;
      conta_den <= '0;
      cociente <= '0;
      resto <= '0;
      Sel <= '0;
      div_zero <= 1'b0;
      divisor <= '0;
      q <= '0;
      r <= '0;
      cnt <= '0;
    end else begin
      if (btn_sel) Sel <= Sel + 2'd1;
      if (state == IDLE) begin
        if (btn_num) conta_num <= sw;
        if (btn_den) conta_den <= sw;
        if (go_ok) begin
          div_zero <= den0;
          divisor <= conta_den;
          r <= '0;
          q <= conta_num;
          cnt <= 2'd3;
          if (den0) begin
            cociente <= 4'hF;
            resto <= conta_num;
          end
        end
      end
      if (state == DIV) begin
        r <= r_n;
        q <= {q[2:0], ge};
        cnt <= cnt - 2'd1;
        if (cnt == 2'd0) begin
          cociente <= {q[2:0], ge};
          resto <= r_n[3:0];
        end
      end
    end
  end
endmodule

// File: tb/tb_num_den_divider.sv
// tb_num_den_divider: vector table plus corner sequences, results checked through a scoreboard queue.
module tb_num_den_divider;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] sw = '0;
  logic btn_num = 1'b0, btn_den = 1'b0, btn_go = 1'b0, btn_sel = 1'b0;
  logic [3:0] conta_num, conta_den, cociente, resto;
  logic [1:0] Sel;
  logic busy, done, div_zero;
  int total = 0, bad = 0;
  typedef struct {logic [3:0] q; logic [3:0] r; logic dz;} result_t;
  typedef struct {logic [3:0] n; logic [3:0] d; logic [3:0] eq; logic [3:0] er; logic dz;} vec_t;
  result_t sb[$];
  vec_t vecs[10];

  num_den_divider dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .btn_num(btn_num), .btn_den(btn_den),
    .btn_go(btn_go), .btn_sel(btn_sel), .conta_num(conta_num), .conta_den(conta_den),
    .cociente(cociente), .resto(resto), .Sel(Sel), .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic load(input logic [3:0] n, input logic [3:0] d);
    @(negedge clk); sw = n; btn_num = 1'b1;
    @(negedge clk); btn_num = 1'b0; sw = d; btn_den = 1'b1;
    @(negedge clk); btn_den = 1'b0;
  endtask

  task automatic go(input logic [3:0] eq, input logic [3:0] er, input logic edz);
    result_t e;
    e.q = eq; e.r = er; e.dz = edz;
    sb.push_back(e);
    @(negedge clk); btn_go = 1'b1;
    @(negedge clk); btn_go = 1'b0;
  endtask

  task automatic wait_result(input logic inj, output int k, output int bc);
    result_t e;
    k = 0; bc = 0;
    while (!done && k < 20) begin
      bc += int'(busy);
      btn_num = inj && k == 1;
      btn_den = inj && k == 1;
      btn_go = inj && k == 1;
      if (inj && k == 1) sw = 4'd9;
      @(negedge clk);
      k++;
    end
    btn_num = 1'b0; btn_den = 1'b0; btn_go = 1'b0;
    chk("done_seen", int'(done), 1);
    if (sb.size() == 0) chk("sb_nonempty", sb.size(), 1);
    else begin
      e = sb.pop_front();
      if (done) begin
        chk("cociente", int'(cociente), int'(e.q));
        chk("resto", int'(resto), int'(e.r));
        chk("div_zero", int'(div_zero), int'(e.dz));
        @(negedge clk);
        chk("done_one_cycle", int'(done), 0);
        chk("cociente_hold", int'(cociente), int'(e.q));
        chk("resto_hold", int'(resto), int'(e.r));
      end
    end
  endtask

  task automatic run(input logic [3:0] n, input logic [3:0] d, input logic [3:0] eq,
                     input logic [3:0] er, input logic edz, input logic inj);
    int k, bc;
    load(n, d);
    go(eq, er, edz);
    wait_result(inj, k, bc);
    chk("latency", k, d == 4'd0 ? 0 : 4);
    chk("busy_cycles", bc, d == 4'd0 ? 0 : 4);
    chk("conta_num", int'(conta_num), int'(n));
    chk("conta_den", int'(conta_den), int'(d));
  endtask

  initial begin
    int k, bc;
    vecs[0] = '{4'd13, 4'd4, 4'd3, 4'd1, 1'b0};
    vecs[1] = '{4'd15, 4'd1, 4'd15, 4'd0, 1'b0};
    vecs[2] = '{4'd3, 4'd7, 4'd0, 4'd3, 1'b0};
    vecs[3] = '{4'd5, 4'd0, 4'hF, 4'd5, 1'b1};
    vecs[4] = '{4'd5, 4'd2, 4'd2, 4'd1, 1'b0};
    vecs[5] = '{4'd15, 4'd15, 4'd1, 4'd0, 1'b0};
    vecs[6] = '{4'd0, 4'd9, 4'd0, 4'd0, 1'b0};
    vecs[7] = '{4'd9, 4'd0, 4'hF, 4'd9, 1'b1};
    vecs[8] = '{4'd8, 4'd3, 4'd2, 4'd2, 1'b0};
    vecs[9] = '{4'd15, 4'd2, 4'd7, 4'd1, 1'b0};
    repeat (2) @(negedge clk);
    chk("rst_num", int'(conta_num), 0);
    chk("rst_den", int'(conta_den), 0);
    chk("rst_coc", int'(cociente), 0);
    chk("rst_resto", int'(resto), 0);
    chk("rst_sel", int'(Sel), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_dz", int'(div_zero), 0);
    rst_n = 1'b1;
    // display select: two pulses idle, two while busy, one after
    btn_sel = 1'b1; @(negedge clk); btn_sel = 1'b0;
    chk("sel_1", int'(Sel), 1);
    btn_sel = 1'b1; @(negedge clk); btn_sel = 1'b0;
    chk("sel_2", int'(Sel), 2);
    load(4'd13, 4'd4);
    go(4'd3, 4'd1, 1'b0);
    chk("busy_after_go", int'(busy), 1);
    btn_sel = 1'b1; @(negedge clk); btn_sel = 1'b0;
    chk("sel_3_busy", int'(Sel), 3);
    btn_sel = 1'b1; @(negedge clk); btn_sel = 1'b0;
    chk("sel_0_busy", int'(Sel), 0);
    chk("still_busy", int'(busy), 1);
    wait_result(1'b0, k, bc);
    chk("sel_run_rest", k, 2);
    btn_sel = 1'b1; @(negedge clk); btn_sel = 1'b0;
    chk("sel_wrap_1", int'(Sel), 1);
    // go coincident with loads is ignored; both loads in one cycle
    @(negedge clk); sw = 4'd6; btn_num = 1'b1; btn_den = 1'b1; btn_go = 1'b1;
    @(negedge clk); btn_num = 1'b0; btn_den = 1'b0; btn_go = 1'b0;
    chk("both_num", int'(conta_num), 6);
    chk("both_den", int'(conta_den), 6);
    chk("go_ignored_busy", int'(busy), 0);
    chk("go_ignored_done", int'(done), 0);
    @(negedge clk);
    chk("go_ignored_busy2", int'(busy), 0);
    for (int i = 0; i < 10; i++) run(vecs[i].n, vecs[i].d, vecs[i].eq, vecs[i].er, vecs[i].dz, 1'b0);
    run(4'd14, 4'd3, 4'd4, 4'd2, 1'b0, 1'b1);
    // reset during the second DIV cycle
    load(4'd13, 4'd4);
    @(negedge clk); btn_go = 1'b1;
    @(negedge clk); btn_go = 1'b0;
    @(negedge clk);
    chk("div2_busy", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_num", int'(conta_num), 0);
    chk("arst_den", int'(conta_den), 0);
    chk("arst_coc", int'(cociente), 0);
    chk("arst_resto", int'(resto), 0);
    chk("arst_sel", int'(Sel), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_done", int'(done), 0);
    chk("arst_dz", int'(div_zero), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("arst_no_done", int'(done), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_done", int'(done), 0);
    chk("post_rst_coc", int'(cociente), 0);
    run(4'd12, 4'd5, 4'd2, 4'd2, 1'b0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
